chi_tx_link_driver: RTL

//  Multi-channel CHI link-layer transmitter, driving the HN_controller rx_req/rx_rsp/rx_dat (and peer) channels.

---
 rtl/chi_tx_link_driver_pkg.sv | 20 ++
 rtl/chi_tx_link_driver_chan.sv | 162 ++++++++++++++++
 rtl/chi_tx_link_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/chi_tx_link_driver_pkg.sv
// -----------------------------------------------------------------------------
// chi_package
// Shared types and constants for the CHI TX link-layer driver.
//   link_state_e        : link FSM encoding, also driven out on link_state
//   CHI_MAX_LCRD        : largest number of L-credits a CHI channel may hold
//   LCRD_RETURN_OPCODE  : opcode (and whole payload) of an LCrdReturn flit
// -----------------------------------------------------------------------------
package chi_package;

    typedef enum logic [1:0] {
        STOP       = 2'd0,
        ACTIVATE   = 2'd1,
        RUN        = 2'd2,
        DEACTIVATE = 2'd3
    } link_state_e;

    localparam int CHI_MAX_LCRD       = 15;
    localparam int LCRD_RETURN_OPCODE = 0;

endpackage

// File: rtl/chi_tx_link_driver_chan.sv
// -----------------------------------------------------------------------------
// chi_tx_chan
// One CHI TX channel: flit FIFO, L-credit counter, FLITPEND/FLITV launch
// registers and the sticky credit-error flag.
// Optional feature (macro CHI_TX_LCRD_RETURN_EN): while the link is in
// DEACTIVATE every held credit is handed back as an all-zero LCrdReturn flit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_link_state      current link FSM state from the top level
//   i_clr_credit      drop all credits (pulse on DEACTIVATE entry)
//   i_in_valid/flit   flit offered by the producer
//   o_in_ready        FIFO not full
//   o_tx_flitpend     launch this cycle, flit appears next cycle
//   o_tx_flitv/flit   launched flit
//   i_tx_lcrdv        one L-credit returned by the receiver
//   o_lcrd_err        sticky credit overflow / out-of-state credit
//   o_empty           FIFO empty (for the top-level reduction)
//   o_credit_zero     no credits held (for the top-level reduction)
// -----------------------------------------------------------------------------
module chi_tx_chan
    import chi_package::*;
#(
    parameter int FLIT_W   = 128,
    parameter int DEPTH    = 8,
    parameter int MAX_LCRD = CHI_MAX_LCRD
) (
    input  logic              clk,
    input  logic              rst,
    input  link_state_e       i_link_state,
    input  logic              i_clr_credit,
    input  logic              i_in_valid,
    input  logic [FLIT_W-1:0] i_in_flit,
    output logic              o_in_ready,
    output logic              o_tx_flitpend,
    output logic              o_tx_flitv,
    output logic [FLIT_W-1:0] o_tx_flit,
    input  logic              i_tx_lcrdv,
    output logic              o_lcrd_err,
    output logic              o_empty,
    output logic              o_credit_zero
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_LCRD + 1);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [LW-1:0]     r_credit;
    logic              r_flitv;
    logic [FLIT_W-1:0] r_flit;
    logic              r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_has_credit;
    logic w_link_live;
    logic w_launch_data;
    logic w_launch_ret;
    logic w_launch;
    logic w_lcrd_ok;
    logic w_lcrd_bad;
    logic w_lcrd_ovf;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    // in_ready depends only on occupancy, so a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign w_push       = i_in_valid & ~w_full;
    assign w_has_credit = (r_credit != '0);
    assign w_link_live  = (i_link_state == RUN) || (i_link_state == DEACTIVATE);

    assign w_launch_data = (i_link_state == RUN) & ~w_empty & w_has_credit;
`ifdef CHI_TX_LCRD_RETURN_EN
    assign w_launch_ret  = (i_link_state == DEACTIVATE) & w_has_credit;
`else
    assign w_launch_ret  = 1'b0;
`endif
    assign w_launch      = w_launch_data | w_launch_ret;

    assign w_lcrd_ok  = i_tx_lcrdv & w_link_live;
    assign w_lcrd_bad = i_tx_lcrdv & ~w_link_live;
    // A credit arriving together with a launch nets to zero, so it can
    // never overflow even when the counter is already at the limit.
    assign w_lcrd_ovf = w_lcrd_ok & ~w_launch & (r_credit == LW'(MAX_LCRD));

    // FIFO storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_launch_data) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_launch_data) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_launch_data) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else if (i_clr_credit) begin
            r_credit <= '0;
        end else if (w_lcrd_ok && !w_launch) begin
            if (!w_lcrd_ovf) begin
                r_credit <= r_credit + 1'b1;
            end
        end else if (!w_lcrd_ok && w_launch) begin
            r_credit <= r_credit - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_lcrd_ovf || w_lcrd_bad) begin
            r_err <= 1'b1;
        end
    end

    // Launch stage boundary: flitpend in cycle N becomes flitv in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flitv <= 1'b0;
            r_flit  <= '0;
        end else begin
            r_flitv <= w_launch;
            if (w_launch_data) begin
                r_flit <= r_mem[r_rd_ptr];
            end else if (w_launch_ret) begin
                r_flit <= FLIT_W'(LCRD_RETURN_OPCODE);
            end
        end
    end

    assign o_in_ready    = ~w_full;
    assign o_tx_flitpend = w_launch;
    assign o_tx_flitv    = r_flitv;
    assign o_tx_flit     = r_flit;
    assign o_lcrd_err    = r_err;
    assign o_empty       = w_empty;
    assign o_credit_zero = ~w_has_credit;

endmodule

// File: rtl/chi_tx_link_driver.sv
// -----------------------------------------------------------------------------
// chi_tx_link_driver
// Multi-channel CHI link-layer transmitter: NUM_CH independent FIFO-buffered,
// credit-counted flit channels plus the TXLINKACTIVE request/ack FSM.
// Optional feature (macro CHI_TX_LCRD_RETURN_EN): credits are returned as
// LCrdReturn flits during DEACTIVATE and STOP waits for all credits to be 0;
// without it credits are simply dropped on DEACTIVATE entry.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   link_en           1 = bring/keep link up, 0 = request deactivate
//   in_valid/in_flit  per-channel flit offered (channel c at [c*FLIT_W +: FLIT_W])
//   in_ready          per-channel FIFO not full
//   tx_flitpend       per-channel flit will be driven next cycle
//   tx_flitv/tx_flit  per-channel launched flit
//   tx_lcrdv          per-channel L-credit grant from the receiver
//   txlinkactivereq   link activation request
//   txlinkactiveack   receiver acknowledge
//   link_state        current link_state_e
//   lcrd_err          per-channel sticky credit error
// -----------------------------------------------------------------------------
module chi_tx_link_driver
    import chi_package::*;
#(
    parameter int NUM_CH   = 3,
    parameter int FLIT_W   = 128,
    parameter int DEPTH    = 8,
    parameter int MAX_LCRD = CHI_MAX_LCRD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     link_en,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*FLIT_W-1:0] in_flit,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [NUM_CH-1:0]        tx_flitpend,
    output logic [NUM_CH-1:0]        tx_flitv,
    output logic [NUM_CH*FLIT_W-1:0] tx_flit,
    input  logic [NUM_CH-1:0]        tx_lcrdv,
    output logic                     txlinkactivereq,
    input  logic                     txlinkactiveack,
    output logic [1:0]               link_state,
    output logic [NUM_CH-1:0]        lcrd_err
);

    link_state_e       r_state;
    link_state_e       w_next;
    logic              w_req;
    logic              w_clr_credit;
    logic              w_all_empty;
    logic              w_busy;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_credit_zero;

    assign w_all_empty = &w_empty;
    // A flit still in its pend->valid window must finish before DEACTIVATE.
    assign w_busy      = (|tx_flitpend) | (|tx_flitv);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STOP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        case (r_state)
            STOP: begin
                if (link_en) begin
                    w_next = ACTIVATE;
                end
            end
            ACTIVATE: begin
                w_req = 1'b1;
                if (txlinkactiveack) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_req = 1'b1;
                if (!link_en && w_all_empty && !w_busy) begin
                    w_next = DEACTIVATE;
                end
            end
            DEACTIVATE: begin
`ifdef CHI_TX_LCRD_RETURN_EN
                if (!txlinkactiveack && (&w_credit_zero)) begin
                    w_next = STOP;
                end
`else
                if (!txlinkactiveack) begin
                    w_next = STOP;
                end
`endif
            end
            default: begin
                w_next = STOP;
            end
        endcase
    end

`ifdef CHI_TX_LCRD_RETURN_EN
    assign w_clr_credit = 1'b0;
`else
    assign w_clr_credit = (r_state == RUN) && (w_next == DEACTIVATE);
`endif

    assign txlinkactivereq = w_req;
    assign link_state      = r_state;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        chi_tx_chan #(
            .FLIT_W   (FLIT_W),
            .DEPTH    (DEPTH),
            .MAX_LCRD (MAX_LCRD)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_link_state  (r_state),
            .i_clr_credit  (w_clr_credit),
            .i_in_valid    (in_valid[c]),
            .i_in_flit     (in_flit[c*FLIT_W +: FLIT_W]),
            .o_in_ready    (in_ready[c]),
            .o_tx_flitpend (tx_flitpend[c]),
            .o_tx_flitv    (tx_flitv[c]),
            .o_tx_flit     (tx_flit[c*FLIT_W +: FLIT_W]),
            .i_tx_lcrdv    (tx_lcrdv[c]),
            .o_lcrd_err    (lcrd_err[c]),
            .o_empty       (w_empty[c]),
            .o_credit_zero (w_credit_zero[c])
        );
    end

endmodule
